// File: rtl/apb_ram_slave.sv
// APB word-addressed RAM slave with WAIT_STATES extra access cycles and registered response.
// Define APB_SLAVE_PROT_CHECK_EN to reject non-secure (PPROT[1]) accesses to the upper half of the RAM.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

module apb_ram_slave #(
    parameter int unsigned ADDR_WIDTH  = `APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = `APB_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    input  logic                        PWRITE,
    input  logic [ADDR_WIDTH-1:0]       PADDR,
    input  logic [DATA_WIDTH-1:0]       PWDATA,
    input  logic [DATA_WIDTH/8-1:0]     PSTRB,
    input  logic [`APB_PROT_WIDTH-1:0]  PPROT,
    output logic [DATA_WIDTH-1:0]       PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERR
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH  = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_WIDTH  = 3;
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
    logic [IDX_WIDTH-1:0]   idx_c;
    logic                   err_c;
    logic                   setup_c;
    logic                   mem_we_c;
    logic [DATA_WIDTH-1:0]  rsp_rdata_c;
    logic                   unused_prot_c;

    assign idx_c         = PADDR[IDX_WIDTH+1:2];
    assign setup_c       = PSEL && !PENABLE;
    assign unused_prot_c = ^PPROT;

    // Misaligned or out-of-range address; optionally non-secure access to the upper half.
    always_comb begin
        err_c = (PADDR[1:0] != 2'b00) || ({1'b0, PADDR} >= ADDR_LIMIT);
`ifdef APB_SLAVE_PROT_CHECK_EN
        if (PPROT[1] && idx_c[IDX_WIDTH-1]) begin
            err_c = 1'b1;
        end
`endif
    end

    // Read data captured on response load; writes leave PRDATA untouched.
    assign rsp_rdata_c = PWRITE ? prdata_q : (err_c ? '0 : mem[idx_c]);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        mem_we_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                if (setup_c) begin
                    cnt_d = CNT_WIDTH'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d   = S_READY;
                        pready_d  = 1'b1;
                        pslverr_d = err_c;
                        prdata_d  = rsp_rdata_c;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d   = S_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d   = S_READY;
                        pready_d  = 1'b1;
                        pslverr_d = err_c;
                        prdata_d  = rsp_rdata_c;
                    end
                end
            end
            S_READY: begin
                if (!PSEL) begin
                    state_d   = S_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (PENABLE) begin
                    mem_we_c  = PWRITE && !err_c;
                    state_d   = S_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
            end
        endcase
    end

    // RAM contents are intentionally not reset.
    always_ff @(posedge PCLK) begin
        if (mem_we_c) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
                if (PSTRB[i]) begin
                    mem[idx_c][8*i +: 8] <= PWDATA[8*i +: 8];
                end
            end
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_ram_slave.sv
// Scoreboard bench for apb_ram_slave: three instances with WAIT_STATES 0, 2 and 3 share one APB bus.
module tb_apb_ram_slave;
    logic        clk;
    logic        rst_n;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    typedef struct {
        int          cycles;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model_mem [3][1024];
    logic [31:0] last_rdata [3];
    int          n_checks;
    int          n_errors;

    apb_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_dut1 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut2 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the completion edge with the bus idle.
    task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
        exp_t        e;
        int          cyc;
        logic        err;
        logic [9:0]  idx;
        logic        obs_err;
        logic [31:0] obs_rdata;
        idx = addr[11:2];
        err = (addr[1:0] != 2'b00) || (addr >= 32'h1000);
`ifdef APB_SLAVE_PROT_CHECK_EN
        if (prot[1] && (idx >= 10'd512)) err = 1'b1;
`endif
        if (!wr) begin
            last_rdata[d] = err ? 32'h0 : model_mem[d][idx];
        end else if (!err) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) model_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        e.cycles = ws_of(d) + 1;
        e.err    = err;
        e.rdata  = last_rdata[d];
        exp_q.push_back(e);

        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        pprot   = prot;
        @(posedge clk);
        #1 penable = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pready[d] && cyc < 16);
        obs_err   = pslverr[d];
        obs_rdata = prdata[d];
        @(posedge clk);
        #1;
        psel    = 3'b000;
        penable = 1'b0;

        e = exp_q.pop_front();
        check_eq("access_cycles", 32'(cyc), 32'(e.cycles));
        check_eq("pslverr", 32'(obs_err), 32'(e.err));
        check_eq("prdata", obs_rdata, e.rdata);
        check_eq("pready_clear", 32'(pready[d]), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        psel     = 3'b000;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        pstrb    = '0;
        pprot    = '0;
        for (int d = 0; d < 3; d++) last_rdata[d] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_eq("reset_pready", 32'(pready[d]), 32'h0);
            check_eq("reset_pslverr", 32'(pslverr[d]), 32'h0);
            check_eq("reset_prdata", prdata[d], 32'h0);
        end
        rst_n = 1'b1;

        // Zero wait states: write then read, first setup right after reset release.
        apb_xfer(0, 1'b1, 32'h04, 32'hA5A5A5A5, 4'hF, 3'b000);
        idle_cycle();
        apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000);

        // Two wait states with partial write, strobe-less write, and strobes ignored on read.
        apb_xfer(1, 1'b1, 32'h04, 32'hA5A5A5A5, 4'hF, 3'b000);
        apb_xfer(1, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000);
        apb_xfer(1, 1'b1, 32'h04, 32'h12345678, 4'h3, 3'b000);
        apb_xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
        apb_xfer(1, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 3'b000);
        apb_xfer(1, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000);

        // Address errors: out of range and misaligned, write and read.
        apb_xfer(1, 1'b1, 32'h1000, 32'hCAFEBABE, 4'hF, 3'b000);
        apb_xfer(1, 1'b1, 32'h06, 32'hCAFEBABE, 4'hF, 3'b000);
        apb_xfer(1, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000);
        apb_xfer(1, 1'b0, 32'h1000, 32'h0, 4'hF, 3'b000);
        apb_xfer(1, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000);
        apb_xfer(1, 1'b0, 32'h06, 32'h0, 4'hF, 3'b000);

        // Protection: the model decides whether PPROT[1] faults in this build.
        apb_xfer(0, 1'b1, 32'h800, 32'h11223344, 4'hF, 3'b000);
        apb_xfer(0, 1'b1, 32'h800, 32'h55667788, 4'hF, 3'b010);
        apb_xfer(0, 1'b0, 32'h800, 32'h0, 4'hF, 3'b000);
        apb_xfer(0, 1'b0, 32'h800, 32'h0, 4'hF, 3'b010);
        apb_xfer(0, 1'b1, 32'h7FC, 32'h0BADF00D, 4'hF, 3'b010);
        apb_xfer(0, 1'b0, 32'h7FC, 32'h0, 4'hF, 3'b010);

        // Back-to-back write then read with no idle cycle.
        apb_xfer(1, 1'b1, 32'h08, 32'h600DD00D, 4'hF, 3'b000);
        apb_xfer(1, 1'b0, 32'h08, 32'h0, 4'hF, 3'b000);
        for (int k = 0; k < 8; k++) begin
            apb_xfer(0, 1'b1, 32'h100 + 32'(4 * k), $urandom, 4'(1 + $urandom_range(14)), 3'b000);
        end
        for (int k = 0; k < 8; k++) begin
            apb_xfer(0, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'hF, 3'b000);
        end

        // PSEL dropped mid-wait: transfer abandoned, nothing written.
        apb_xfer(1, 1'b1, 32'h0C, 32'h33333333, 4'hF, 3'b000);
        psel    = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        pwdata  = 32'h77777777;
        pstrb   = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1;
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_pready", 32'(pready[1]), 32'h0);
        apb_xfer(1, 1'b0, 32'h0C, 32'h0, 4'hF, 3'b000);

        // Asynchronous reset during wait states aborts the write.
        apb_xfer(2, 1'b1, 32'h10, 32'h11111111, 4'hF, 3'b000);
        apb_xfer(2, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'hDEADBEEF;
        pstrb   = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_pready", 32'(pready[2]), 32'h0);
        check_eq("async_rst_pslverr", 32'(pslverr[2]), 32'h0);
        check_eq("async_rst_prdata", prdata[2], 32'h0);
        psel    = 3'b000;
        penable = 1'b0;
        for (int d = 0; d < 3; d++) last_rdata[d] = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        apb_xfer(2, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
        apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
